// File: rtl/radar_burst_controller.sv
// radar_burst_controller: multi-channel chirp burst sequencer for the FMC150 radar path.
// One arm pulse fires cfg_burst_len chirps at a PRI of cfg_pri cycles. The chirps rotate
// round-robin over the channels enabled in cfg_ch_mask. Each pulse opens a delayed ADC window.
// Optional feature macro: BURST_CONTINUOUS_EN. When it is defined, burst_len==0 arms a
// continuous burst that runs until abort. When it is undefined, an arm with burst_len==0
// is rejected with a fault pulse.
module radar_burst_controller #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_fmc150,
  input  logic               aresetn,
  input  logic [CNT_W-1:0]   cfg_pri,
  input  logic [CNT_W-1:0]   cfg_adc_delay,
  input  logic [CNT_W-1:0]   cfg_adc_len,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [NUM_CH-1:0]  cfg_ch_mask,
  input  logic               arm,
  input  logic               abort,
  input  logic               chirp_ready,
  input  logic               chirp_done,
  output logic [NUM_CH-1:0]  chirp_init,
  output logic [NUM_CH-1:0]  chirp_enable,
  output logic               adc_enable,
  output logic [CH_W-1:0]    adc_ch_sel,
  output logic [BURST_W-1:0] pulse_index,
  output logic               busy,
  output logic               burst_done,
  output logic               fault
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_CHIRP  = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         state, state_nx;
  logic [CNT_W-1:0]   sh_pri, sh_dly, sh_len;
  logic [BURST_W-1:0] sh_blen;
  logic [NUM_CH-1:0]  sh_mask;
  logic [CNT_W-1:0]   pri_cnt;
  // Cycles elapsed since the last chirp_init. It saturates once the window has closed,
  // and all-ones means that no window is pending.
  logic [CNT_W:0]     adc_cnt;
  logic [CNT_W+1:0]   win_end, win_ld, adc_nxt;
  logic [CNT_W-1:0]   pri_ld, dly_ld, len_ld, pri_m1;
  logic [CH_W-1:0]    ch_ld;
  logic               accept, bad_arm, blen_bad, last_pulse, adc_closed, fault_nx;

  function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) first_ch = CH_W'(i);
  endfunction

  // The next enabled channel strictly above c, wrapping to the lowest one.
  function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
    next_ch = c;
    for (int k = NUM_CH; k >= 1; k--) begin
      int j;
      j = (int'(c) + k) % NUM_CH;
      if (m[j]) next_ch = CH_W'(j);
    end
  endfunction

`ifdef BURST_CONTINUOUS_EN
  logic sh_cont;
  assign blen_bad   = 1'b0;
  assign last_pulse = !sh_cont && (pulse_index == sh_blen - BURST_W'(1));

  // Latch the continuous-mode flag together with the rest of the shadow config.
  always_ff @(posedge clk_fmc150) begin
    if (!aresetn)    sh_cont <= 1'b0;
    else if (accept) sh_cont <= (cfg_burst_len == '0);
  end
`else
  assign blen_bad   = (cfg_burst_len == '0);
  assign last_pulse = (pulse_index == sh_blen - BURST_W'(1));
`endif

  // Arm qualification, the config used at launch, and the ADC window bookkeeping.
  always_comb begin
    bad_arm    = (state == S_IDLE) && arm && !abort && ((cfg_ch_mask == '0) || blen_bad);
    accept     = (state == S_IDLE) && arm && !abort && chirp_ready && !bad_arm;
    pri_ld     = accept ? cfg_pri       : sh_pri;
    dly_ld     = accept ? cfg_adc_delay : sh_dly;
    len_ld     = accept ? cfg_adc_len   : sh_len;
    pri_m1     = (pri_ld == '0) ? '0 : pri_ld - CNT_W'(1);
    ch_ld      = accept ? first_ch(cfg_ch_mask) : next_ch(sh_mask, adc_ch_sel);
    win_ld     = (len_ld == '0) ? '0 : {2'b0, dly_ld} + {2'b0, len_ld};
    win_end    = (sh_len == '0) ? '0 : {2'b0, sh_dly} + {2'b0, sh_len};
    adc_nxt    = {1'b0, adc_cnt} + (CNT_W+2)'(1);
    // "Closed" means that the window is no longer high on the next cycle, so a new launch
    // can follow right after the last enabled cycle.
    adc_closed = (adc_nxt >= win_end);
  end

  // Burst sequencing. Abort overrides every other transition and suppresses the fault.
  always_comb begin
    state_nx = state;
    fault_nx = bad_arm;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_CHIRP;
      S_CHIRP:
        if (chirp_done) state_nx = S_DWELL;
        else if (pri_cnt == '0) begin
          state_nx = S_IDLE;
          fault_nx = 1'b1;
        end
      S_DWELL:
        if ((pri_cnt == '0) && adc_closed && chirp_ready)
          state_nx = last_pulse ? S_DONE : S_LAUNCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      fault_nx = 1'b0;
    end
  end

  // Shadow config. It is captured only when an arm is accepted.
  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      sh_pri  <= CNT_W'(245760);
      sh_dly  <= '0;
      sh_len  <= CNT_W'(200);
      sh_blen <= BURST_W'(1);
      sh_mask <= NUM_CH'(1);
    end else if (accept) begin
      sh_pri  <= cfg_pri;
      sh_dly  <= cfg_adc_delay;
      sh_len  <= cfg_adc_len;
      sh_blen <= cfg_burst_len;
      sh_mask <= cfg_ch_mask;
    end
  end

  // State, registered outputs, the PRI down-counter and the ADC window timer.
  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      burst_done   <= 1'b0;
      fault        <= 1'b0;
      chirp_init   <= '0;
      chirp_enable <= '0;
      adc_enable   <= 1'b0;
      adc_ch_sel   <= '0;
      pulse_index  <= '0;
      pri_cnt      <= '0;
      adc_cnt      <= '1;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != S_IDLE);
      burst_done <= (state_nx == S_DONE);
      fault      <= fault_nx;
      if (state_nx == S_LAUNCH) begin
        adc_ch_sel   <= ch_ld;
        pulse_index  <= accept ? '0 : pulse_index + BURST_W'(1);
        chirp_init   <= NUM_CH'(1) << ch_ld;
        chirp_enable <= NUM_CH'(1) << ch_ld;
        pri_cnt      <= pri_m1;
        adc_cnt      <= '0;
        adc_enable   <= (dly_ld == '0) && (len_ld != '0);
      end else if (state_nx == S_IDLE) begin
        chirp_init   <= '0;
        chirp_enable <= '0;
        adc_enable   <= 1'b0;
        adc_cnt      <= '1;
      end else begin
        chirp_init <= '0;
        if ((state == S_CHIRP) && chirp_done) chirp_enable <= '0;
        if (pri_cnt != '0) pri_cnt <= pri_cnt - CNT_W'(1);
        if ({1'b0, adc_cnt} < win_end) adc_cnt <= adc_cnt + (CNT_W+1)'(1);
        adc_enable <= (adc_nxt >= {2'b0, sh_dly}) && (adc_nxt < win_end);
      end
    end
  end
endmodule

// File: tb/tb_radar_burst_controller.sv
// Testbench for radar_burst_controller. It runs directed bursts and then randomized bursts.
// Each burst is checked against a timeline computed from the burst rules.
module tb_radar_burst_controller;
  logic        clk_fmc150 = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_pri = '0, cfg_adc_delay = '0, cfg_adc_len = '0;
  logic [15:0] cfg_burst_len = '0;
  logic [1:0]  cfg_ch_mask = '0;
  logic        arm = 1'b0, abort = 1'b0, chirp_ready = 1'b1, chirp_done = 1'b0;
  logic [1:0]  chirp_init, chirp_enable;
  logic        adc_enable, busy, burst_done, fault;
  logic [0:0]  adc_ch_sel;
  logic [15:0] pulse_index;

  radar_burst_controller #(.NUM_CH(2), .CNT_W(32), .BURST_W(16)) dut (
    .clk_fmc150(clk_fmc150), .aresetn(aresetn),
    .cfg_pri(cfg_pri), .cfg_adc_delay(cfg_adc_delay), .cfg_adc_len(cfg_adc_len),
    .cfg_burst_len(cfg_burst_len), .cfg_ch_mask(cfg_ch_mask),
    .arm(arm), .abort(abort), .chirp_ready(chirp_ready), .chirp_done(chirp_done),
    .chirp_init(chirp_init), .chirp_enable(chirp_enable), .adc_enable(adc_enable),
    .adc_ch_sel(adc_ch_sel), .pulse_index(pulse_index), .busy(busy),
    .burst_done(burst_done), .fault(fault));

  always #2 clk_fmc150 = ~clk_fmc150;

  int cyc = 0;
  always @(posedge clk_fmc150) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;
  int chirp_lat = 1, rem = 0;
  int init_t[$], init_pi[$], init_sel[$], done_t[$], fault_t[$];
  logic [1:0] init_oh[$];
  logic [1:0] en_hist[int];
  logic       adc_hist[int], busy_hist[int];

  // Records outputs every cycle and plays the chirp generator: chirp_done comes chirp_lat
  // cycles after each chirp_init. chirp_lat==0 means that chirp_done never comes.
  always @(negedge clk_fmc150) begin
    en_hist[cyc] = chirp_enable;
    adc_hist[cyc] = adc_enable;
    busy_hist[cyc] = busy;
    if (chirp_init != 2'b00) begin
      init_t.push_back(cyc); init_oh.push_back(chirp_init);
      init_sel.push_back(int'(adc_ch_sel)); init_pi.push_back(int'(pulse_index));
    end
    if (burst_done) done_t.push_back(cyc);
    if (fault) fault_t.push_back(cyc);
    chirp_done = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) chirp_done = 1'b1;
    end
    if (chirp_init != 2'b00 && chirp_lat > 0) rem = chirp_lat;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Spacing between inits: the PRI, the whole ADC window, or the chirp itself plus the DWELL cycle.
  function automatic int model_period(input int pri, input int dly, input int len, input int lat);
    return max3((pri == 0) ? 1 : pri, (len == 0) ? 0 : dly + len, lat + 2);
  endfunction

  task automatic start_burst(input int pri, input int dly, input int len, input int blen,
                             input logic [1:0] mask, input int lat, output int arm_c);
    @(negedge clk_fmc150);
    cfg_pri = 32'(pri); cfg_adc_delay = 32'(dly); cfg_adc_len = 32'(len);
    cfg_burst_len = 16'(blen); cfg_ch_mask = mask; chirp_lat = lat;
    init_t.delete(); init_oh.delete(); init_sel.delete(); init_pi.delete();
    done_t.delete(); fault_t.delete();
    arm = 1'b1; arm_c = cyc;
    @(negedge clk_fmc150);
    arm = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (done_t.size() == 0 && fault_t.size() == 0 && k < budget) begin
      @(negedge clk_fmc150); k++;
    end
    chk({tag, ".ended"}, longint'(done_t.size() + fault_t.size() > 0), 1);
    repeat (6) @(negedge clk_fmc150);
  endtask

  // Full-burst check. Pulse i is launched at arm+1+i*period on the i-th enabled channel
  // (in ascending order, wrapping). chirp_enable is high from the init cycle through the
  // chirp_done cycle. The ADC window covers [init+dly, init+dly+len). burst_done comes one
  // period after the last init.
  task automatic check_burst(input string tag, input int arm_c, input int pri, input int dly,
                             input int len, input int blen, input logic [1:0] mask, input int lat);
    int p, chs[$], n, bad_en, bad_adc, lim;
    logic [1:0] one, exp_en;
    logic exp_adc;
    one = 2'b01;
    p = model_period(pri, dly, len, lat);
    for (int i = 0; i < 2; i++) if (mask[i]) chs.push_back(i);
    chk({tag, ".n_init"}, init_t.size(), blen);
    n = (init_t.size() < blen) ? init_t.size() : blen;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.init_t%0d", tag, i), init_t[i], arm_c + 1 + i * p);
      chk($sformatf("%s.init_oh%0d", tag, i), init_oh[i], one << chs[i % chs.size()]);
      chk($sformatf("%s.ch_sel%0d", tag, i), init_sel[i], chs[i % chs.size()]);
      chk($sformatf("%s.pidx%0d", tag, i), init_pi[i], i);
    end
    chk({tag, ".n_done"}, done_t.size(), 1);
    if (done_t.size() > 0) chk({tag, ".done_t"}, done_t[0], arm_c + 1 + blen * p);
    chk({tag, ".n_fault"}, fault_t.size(), 0);
    bad_en = 0; bad_adc = 0;
    lim = arm_c + 1 + blen * p + 4;
    for (int t = arm_c + 1; t <= lim; t++) begin
      exp_en = 2'b00; exp_adc = 1'b0;
      for (int i = 0; i < blen; i++) begin
        int t0;
        t0 = arm_c + 1 + i * p;
        if (t >= t0 && t <= t0 + lat) exp_en = one << chs[i % chs.size()];
        if (t >= t0 + dly && t < t0 + dly + len) exp_adc = 1'b1;
      end
      if (!en_hist.exists(t) || en_hist[t] !== exp_en) bad_en++;
      if (!adc_hist.exists(t) || adc_hist[t] !== exp_adc) bad_adc++;
    end
    chk({tag, ".chirp_en_cycles_bad"}, bad_en, 0);
    chk({tag, ".adc_cycles_bad"}, bad_adc, 0);
  endtask

  initial begin
    int a, bad, pri, dly, len, blen, lat;
    logic [1:0] mask;

    // Reset and idle.
    repeat (5) @(negedge clk_fmc150);
    chk("reset_outs", longint'({chirp_init, chirp_enable, adc_enable, adc_ch_sel, pulse_index, busy, burst_done, fault}), 0);
    aresetn = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk_fmc150);
      if ({chirp_init, chirp_enable, adc_enable, adc_ch_sel, pulse_index, busy, burst_done, fault} != '0) bad++;
    end
    chk("idle_100_nonzero_cycles", bad, 0);

    // A basic 4-pulse burst over two channels.
    start_burst(1000, 10, 200, 4, 2'b11, 300, a);
    wait_end("basic", 5000);
    check_burst("basic", a, 1000, 10, 200, 4, 2'b11, 300);

    // The ADC window stretches the PRI.
    start_burst(100, 50, 200, 3, 2'b01, 30, a);
    wait_end("stretch", 1500);
    check_burst("stretch", a, 100, 50, 200, 3, 2'b01, 30);

    // A missing chirp_done leads to a fault at PRI expiry.
    start_burst(100, 0, 10, 2, 2'b01, 0, a);
    wait_end("timeout", 400);
    chk("timeout.n_fault", fault_t.size(), 1);
    chk("timeout.n_done", done_t.size(), 0);
    if (fault_t.size() > 0 && init_t.size() > 0) begin
      chk("timeout.fault_t", fault_t[0], init_t[0] + 100);
      chk("timeout.busy_at_fault", busy_hist[fault_t[0]], 0);
      chk("timeout.en_at_fault", en_hist[fault_t[0]], 0);
      chk("timeout.en_before_fault", en_hist[fault_t[0] - 1], 2'b01);
    end
    repeat (20) @(negedge clk_fmc150);

    // Abort in the DWELL of pulse 2. Config writes made mid-burst must be ignored.
    start_burst(500, 10, 100, 4, 2'b11, 50, a);
    cfg_pri = 32'd300; cfg_ch_mask = 2'b01; cfg_adc_len = 32'd20;
    while (cyc < a + 1200) @(negedge clk_fmc150);
    abort = 1'b1;
    @(negedge clk_fmc150);
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.chirp_en", chirp_enable, 0);
    chk("abort.adc_en", adc_enable, 0);
    chk("abort.n_init", init_t.size(), 3);
    if (init_t.size() >= 3) begin
      chk("abort.spacing", init_t[2] - init_t[1], 500);
      chk("abort.oh1", init_oh[1], 2'b10);
      bad = 0;
      for (int t = init_t[1]; t < init_t[1] + 200; t++) if (adc_hist[t]) bad++;
      chk("abort.adc_len_old_cfg", bad, 100);
    end
    repeat (60) @(negedge clk_fmc150);
    chk("abort.n_done", done_t.size(), 0);
    chk("abort.n_fault", fault_t.size(), 0);
    // The new config takes effect on the next arm.
    start_burst(300, 10, 20, 4, 2'b01, 50, a);
    wait_end("rearm", 2000);
    check_burst("rearm", a, 300, 10, 20, 4, 2'b01, 50);

    // Arms with a bad config.
    start_burst(100, 0, 10, 2, 2'b00, 10, a);
    repeat (4) @(negedge clk_fmc150);
    chk("mask0.n_fault", fault_t.size(), 1);
    if (fault_t.size() > 0) chk("mask0.fault_t", fault_t[0], a + 1);
    chk("mask0.n_init", init_t.size(), 0);
    chk("mask0.busy", busy_hist[a + 1], 0);
    start_burst(50, 0, 20, 0, 2'b01, 10, a);
`ifdef BURST_CONTINUOUS_EN
    while (cyc < a + 160) @(negedge clk_fmc150);
    chk("cont.n_init", init_t.size(), 4);
    if (init_t.size() >= 2) chk("cont.spacing", init_t[1] - init_t[0], 50);
    abort = 1'b1;
    @(negedge clk_fmc150);
    abort = 1'b0;
    chk("cont.busy_after_abort", busy, 0);
    chk("cont.n_done", done_t.size(), 0);
`else
    repeat (4) @(negedge clk_fmc150);
    chk("blen0.n_fault", fault_t.size(), 1);
    chk("blen0.n_init", init_t.size(), 0);
`endif
    repeat (20) @(negedge clk_fmc150);

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      pri  = int'($urandom_range(200, 20));
      dly  = int'($urandom_range(150, 0));
      len  = int'($urandom_range(150, 0));
      blen = int'($urandom_range(5, 1));
      lat  = int'($urandom_range(pri - 1, 1));
      mask = 2'($urandom_range(3, 1));
      start_burst(pri, dly, len, blen, mask, lat, a);
      wait_end($sformatf("rnd%0d", r), 3000);
      check_burst($sformatf("rnd%0d", r), a, pri, dly, len, blen, mask, lat);
      repeat (5) @(negedge clk_fmc150);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
